fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of async_fifo among NREQ requesters on the write clock domain.
- Grants one requester at a time for a bounded burst and drives registered wdata/winc.
- Throttles on wfull/almost_full so the FIFO can never be overrun.
- Exposes a transfer counter and a stall counter for debug and testbench scoreboarding.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DSIZE, 8, data width; must equal the FIFO DSIZE.
- MAX_BURST, 4, maximum beats per grant (1..16).
- CNTW, 16, width of the status counters.

Ports:
- wclk  in  1  write-domain clock; all logic on posedge.
- wrst_n  in  1  asynchronous active-low reset.
- arb_en  in  1  arbitration enable.
- req_valid  in  NREQ  per-requester data valid.
- req_data  in  NREQ*DSIZE  per-requester data; requester i occupies bits [i*DSIZE +: DSIZE].
- req_ready  out  NREQ  per-requester accept; combinational.
- wdata  out  DSIZE  FIFO write data; registered.
- winc  out  1  FIFO write strobe; registered, one beat per cycle.
- wfull  in  1  FIFO full flag.
- almost_full  in  1  FIFO almost-full flag; contract: asserted whenever 1 or fewer slots are free.
- gnt_valid  out  1  a burst is in progress (state BURST).
- gnt_id  out  $clog2(NREQ)  index of the current grantee; 0 when idle.
- wr_count  out  CNTW  total winc pulses; wraps modulo 2^CNTW.
- stall_count  out  CNTW  cycles the grantee was valid but stalled; saturates at all-ones.

Behaviour:
- Reset (wrst_n=0, asynchronous):
  - Outputs: winc=0, wdata=0, gnt_valid=0, gnt_id=0, req_ready=0, wr_count=0, stall_count=0.
  - Internal: state=IDLE, rr pointer=0, beat count=0.
  - Reset asserted mid-burst drops winc in the same instant; the beat in flight is lost. No recovery is attempted.
- stall = wfull | (almost_full & winc). A beat already in flight plus almost_full blocks the next beat.
- req_ready[i] = (state==BURST) & (gnt_id==i) & ~stall. All other requesters see 0.
- Transfer: req_valid[g] & req_ready[g] at a posedge. On that edge:
  - wdata <= req_data[g], winc <= 1, beat count +1, wr_count +1 (counted when winc is registered).
  - Otherwise winc <= 0 and wdata holds its value.
- IDLE state:
  - If arb_en and any req_valid: pick the first set bit scanning upward from rr pointer, wrapping modulo NREQ.
  - Load gnt_id, clear beat count, go to BURST.
  - Grant latency: 1 cycle from valid to gnt_valid. The first transfer happens no earlier than the cycle after the grant.
- BURST state:
  - Leave to IDLE on the edge where any of these holds:
    - a transfer makes beat count equal MAX_BURST;
    - req_valid[g]=0 (requester released, regardless of stall);
    - arb_en=0. A transfer on that same edge still completes.
  - On exit, rr pointer <= (g+1) mod NREQ.
  - A stalled cycle with req_valid[g]=1 holds the grant and increments stall_count.
- No IDLE bubble is skipped: consecutive bursts always have at least one IDLE cycle between them. Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- Only one requester is ready per cycle. NREQ not a power of two is legal; unused pointer codes never occur.
- gnt_id changes only on IDLE->BURST. req_data of non-grantees is ignored.
- wfull asserting mid-burst: stop accepting immediately (same cycle, combinationally) and resume when it clears. Never drive winc=1 on a cycle where wfull=1 was sampled at the preceding edge with no transfer.

Test Plan:
- Single requester 0 sends 0xAA,0xBB,0xCC,0xDD with MAX_BURST=4 -> winc pulses on 4 consecutive cycles starting the cycle after the grant; wdata sequence AA,BB,CC,DD; wr_count=4; returns to IDLE; rr pointer=1.
- All four requesters continuously valid, 8 beats each -> grants in order 0,1,2,3,0,1,2,3 with 4 beats each and 1 IDLE cycle between bursts; final wr_count=32; FIFO readback order matches the grant order.
- Fill a 16-entry FIFO with the reader stopped -> req_ready drops once almost_full is seen while a write is in flight; no winc while wfull=1; exactly 16 entries written; stall_count increments every cycle after that; resuming reads resumes writes with no lost or duplicated data.
- Requester 2 drops valid after 2 beats -> burst ends, rr pointer=3; requester 3 is granted next even though requester 2 reasserts.
- arb_en=0 while IDLE with requests pending -> gnt_valid stays 0; arb_en deasserted mid-burst -> that beat completes, then IDLE, and no further grants until arb_en=1.
- wrst_n pulsed low mid-burst -> winc, gnt_valid and both counters go to 0 asynchronously; after release, the first grant goes to the lowest valid requester scanning from index 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async_fifo write port among NREQ write-domain requesters.
// Grants bounded bursts, registers wdata/winc, and throttles on wfull/almost_full.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4,
  parameter int CNTW      = 16
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic                     arb_en,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DSIZE-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [DSIZE-1:0]         wdata,
  output logic                     winc,
  input  logic                     wfull,
  input  logic                     almost_full,
  output logic                     gnt_valid,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic [CNTW-1:0]          wr_count,
  output logic [CNTW-1:0]          stall_count,
  output logic                     dbg_state,
  output logic [$clog2(NREQ)-1:0]  dbg_rr_ptr
);

  localparam int IDW = $clog2(NREQ);
  localparam int BW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t          state, state_nx;
  logic [IDW-1:0]  gnt_id_r;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  pick_id;
  logic            pick_found;
  logic [BW-1:0]   beat_cnt;
  logic            g_valid;
  logic            stall;
  logic            xfer;
  logic            last_beat;
  logic            burst_end;

  // Handshake: a beat moves on a posedge where req_valid[i] & req_ready[i]; the
  // requester must hold req_data stable while valid and not yet accepted.
  // A beat already in flight counts against the last free slot, hence almost_full & winc.
  assign stall     = wfull | (almost_full & winc);
  assign g_valid   = req_valid[gnt_id_r];
  assign xfer      = (state == BURST) & g_valid & ~stall;
  assign last_beat = xfer & (beat_cnt == BW'(MAX_BURST - 1));
  assign burst_end = (state == BURST) & (last_beat | ~g_valid | ~arb_en);

  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = IDW'(idx);
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (arb_en && pick_found) state_nx = BURST;
      BURST:   if (burst_end)            state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt_valid  = (state == BURST);
    gnt_id     = gnt_valid ? gnt_id_r : '0;
    dbg_state  = (state == BURST);
    dbg_rr_ptr = rr_ptr;
    req_ready  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = gnt_valid & (gnt_id_r == IDW'(i)) & ~stall;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      winc        <= 1'b0;
      wdata       <= '0;
      gnt_id_r    <= '0;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      wr_count    <= '0;
      stall_count <= '0;
    end else begin
      winc <= xfer;
      if (xfer) begin
        wdata    <= req_data[int'(gnt_id_r)*DSIZE +: DSIZE];
        wr_count <= wr_count + 1'b1;
      end
      if (state == IDLE && state_nx == BURST) begin
        gnt_id_r <= pick_id;
        beat_cnt <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (burst_end) begin
        rr_ptr <= (gnt_id_r == IDW'(NREQ - 1)) ? '0 : gnt_id_r + 1'b1;
      end
      if ((state == BURST) && g_valid && stall && !(&stall_count)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule
